pi_loop_gain_scheduler: RTL and testbench

Acquisition/tracking controller for the ZCTED PI loop filter. It watches the zero-stuffed timing error stream and declares lock or loss of lock from a smoothed |error| metric. It drives the filter's proportional gain (K1) and integral gain (K2): wide gains during acquisition, narrow gains during tracking. It also clears the filter integrator on (re)acquisition and gives up after a bounded number of retries.

---
 rtl/pi_loop_gain_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_pi_loop_gain_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_loop_gain_scheduler.sv
// pi_loop_gain_scheduler
// Acquisition/tracking controller for the ZCTED PI loop filter. Smooths the
// magnitude of the zero-stuffed timing error and declares lock or loss of lock
// from it. Selects wide gains while acquiring and narrow gains while tracking.
// Clears the loop integrator on every (re)acquisition. Gives up after
// MAX_RETRY unsuccessful acquisition attempts.
// Optional feature macro: PI_GAIN_RAMP_EN. When it is defined, the gains are
// not switched directly on lock. They start at the acquisition values and
// halve every RAMP_STEP samples until they reach the tracking values.

module pi_loop_gain_scheduler #(
    parameter int                     DATA_WIDTH  = 16,
    parameter int                     COEFF_WIDTH = 16,
    parameter int                     AVG_SHIFT   = 4,
    parameter logic [COEFF_WIDTH-1:0] K1_ACQ      = 16'h0100,
    parameter logic [COEFF_WIDTH-1:0] K2_ACQ      = 16'h0020,
    parameter logic [COEFF_WIDTH-1:0] K1_TRK      = 16'h0020,
    parameter logic [COEFF_WIDTH-1:0] K2_TRK      = 16'h0004,
    parameter int                     LOCK_CNT    = 64,
    parameter int                     UNLOCK_CNT  = 32,
    parameter int                     ACQ_TIMEOUT = 4096,
    parameter int                     MAX_RETRY   = 3
`ifdef PI_GAIN_RAMP_EN
    ,
    parameter int                     RAMP_STEP   = 8
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          zs_valid,
    input  logic signed [DATA_WIDTH-1:0]  e_k_zs,
    input  logic        [DATA_WIDTH-1:0]  lock_thr,
    input  logic        [DATA_WIDTH-1:0]  unlock_thr,
    output logic signed [COEFF_WIDTH-1:0] k1,
    output logic signed [COEFF_WIDTH-1:0] k2,
    output logic                          integ_clr,
    output logic                          locked,
    output logic                          fail,
    output logic        [1:0]             state,
    output logic        [DATA_WIDTH-1:0]  err_avg
);

    localparam int ACC_W   = DATA_WIDTH + AVG_SHIFT;
    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam int ACQ_W   = $clog2(ACQ_TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [GOOD_W-1:0]     LOCK_LIM    = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]      UNLOCK_LIM  = BAD_W'(UNLOCK_CNT);
    localparam logic [ACQ_W-1:0]      TIMEOUT_LIM = ACQ_W'(ACQ_TIMEOUT);
    localparam logic [RETRY_W-1:0]    RETRY_LIM   = RETRY_W'(MAX_RETRY);
    localparam logic [DATA_WIDTH-1:0] E_MIN       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] E_MAX       = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t              cur_state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_step;
    logic [DATA_WIDTH-1:0] abs_e;
    logic [GOOD_W-1:0]   good_cnt;
    logic [GOOD_W-1:0]   good_next;
    logic [BAD_W-1:0]    bad_cnt;
    logic [BAD_W-1:0]    bad_next;
    logic [ACQ_W-1:0]    acq_cnt;
    logic [ACQ_W-1:0]    acq_next;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [RETRY_W-1:0]  retry_next;
    logic [RETRY_W-1:0]  retry_load;
    logic                lock_hit;
    logic                timeout_hit;
    logic                unlock_hit;
    logic                enter_acq;
    logic                enter_track;
    logic                enter_fail;

    assign state   = cur_state;
    assign err_avg = acc[ACC_W-1:AVG_SHIFT];

    // Saturating magnitude of the error sample: the most negative code maps to full scale
    always_comb begin
        abs_e = e_k_zs;
        if (e_k_zs == E_MIN)
            abs_e = E_MAX;
        else if (e_k_zs[DATA_WIDTH-1])
            abs_e = ~e_k_zs + DATA_WIDTH'(1);
    end

    // Averager step and the per-sample lock / unlock / timeout decisions on the pre-update average
    always_comb begin
        acc_step    = acc + ACC_W'(abs_e) - (acc >> AVG_SHIFT);
        good_next   = (err_avg < lock_thr)   ? good_cnt + 1'b1 : '0;
        bad_next    = (err_avg > unlock_thr) ? bad_cnt + 1'b1  : '0;
        acq_next    = acq_cnt + 1'b1;
        retry_next  = retry_cnt + 1'b1;
        lock_hit    = zs_valid && (good_next == LOCK_LIM);
        timeout_hit = zs_valid && (acq_next == TIMEOUT_LIM);
        unlock_hit  = zs_valid && (bad_next == UNLOCK_LIM);
        enter_acq   = 1'b0;
        enter_track = 1'b0;
        enter_fail  = 1'b0;
        retry_load  = '0;
        if (enable) begin
            case (cur_state)
                S_IDLE: enter_acq = 1'b1;
                S_ACQ: begin
                    if (lock_hit) begin
                        enter_track = 1'b1;
                    end else if (timeout_hit) begin
                        if (retry_next == RETRY_LIM) begin
                            enter_fail = 1'b1;
                        end else begin
                            enter_acq  = 1'b1;
                            retry_load = retry_next;
                        end
                    end
                end
                S_TRACK: enter_acq = unlock_hit;
                default: ;
            endcase
        end
    end

`ifdef PI_GAIN_RAMP_EN
    localparam int               RAMP_W    = $clog2(RAMP_STEP + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP - 1);

    logic [RAMP_W-1:0]             ramp_cnt;
    logic signed [COEFF_WIDTH-1:0] k1_ramp;
    logic signed [COEFF_WIDTH-1:0] k2_ramp;

    // Next ramp gains: halve each, but never drop below its tracking value
    always_comb begin
        k1_ramp = k1 >>> 1;
        k2_ramp = k2 >>> 1;
        if (k1_ramp < $signed(K1_TRK))
            k1_ramp = K1_TRK;
        if (k2_ramp < $signed(K2_TRK))
            k2_ramp = K2_TRK;
    end
`endif

    // Controller state, registered gains and flags, counters and the leaky averager
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            acc       <= '0;
            k1        <= '0;
            k2        <= '0;
            integ_clr <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            acq_cnt   <= '0;
            retry_cnt <= '0;
`ifdef PI_GAIN_RAMP_EN
            ramp_cnt  <= '0;
`endif
        end else begin
            if (zs_valid)
                acc <= acc_step;
            if (!enable) begin
                cur_state <= S_IDLE;
                k1        <= '0;
                k2        <= '0;
                integ_clr <= 1'b1;
                locked    <= 1'b0;
                fail      <= 1'b0;
                good_cnt  <= '0;
                bad_cnt   <= '0;
                acq_cnt   <= '0;
                retry_cnt <= '0;
            end else if (enter_acq) begin
                cur_state <= S_ACQ;
                acc       <= '1;
                k1        <= K1_ACQ;
                k2        <= K2_ACQ;
                integ_clr <= 1'b1;
                locked    <= 1'b0;
                fail      <= 1'b0;
                good_cnt  <= '0;
                bad_cnt   <= '0;
                acq_cnt   <= '0;
                retry_cnt <= retry_load;
            end else if (enter_track) begin
                cur_state <= S_TRACK;
                integ_clr <= 1'b0;
                locked    <= 1'b1;
                bad_cnt   <= '0;
`ifdef PI_GAIN_RAMP_EN
                k1        <= K1_ACQ;
                k2        <= K2_ACQ;
                ramp_cnt  <= '0;
`else
                k1        <= K1_TRK;
                k2        <= K2_TRK;
`endif
            end else if (enter_fail) begin
                cur_state <= S_FAIL;
                k1        <= '0;
                k2        <= '0;
                integ_clr <= 1'b1;
                fail      <= 1'b1;
                retry_cnt <= retry_next;
            end else begin
                case (cur_state)
                    S_ACQ: begin
                        integ_clr <= 1'b0;
                        if (zs_valid) begin
                            good_cnt <= good_next;
                            acq_cnt  <= acq_next;
                        end
                    end
                    S_TRACK: begin
                        if (zs_valid) begin
                            bad_cnt <= bad_next;
`ifdef PI_GAIN_RAMP_EN
                            if (ramp_cnt == RAMP_LAST) begin
                                ramp_cnt <= '0;
                                k1       <= k1_ramp;
                                k2       <= k2_ramp;
                            end else begin
                                ramp_cnt <= ramp_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pi_loop_gain_scheduler.sv
// tb_pi_loop_gain_scheduler
// Self-checking bench for pi_loop_gain_scheduler. The main instance uses the
// default parameters. A second instance uses a short acquisition timeout and
// a short lock count, which keeps the retry and lock/timeout corners compact.
// Honours PI_GAIN_RAMP_EN for the expected gains after lock.

module tb_pi_loop_gain_scheduler;

    typedef struct {
        logic        valid;
        logic [15:0] e;
        logic [15:0] exp_avg;
        logic        exp_clr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        enable_t;
    logic        zs_valid;
    logic [15:0] e_k_zs;
    logic [15:0] lock_thr;
    logic [15:0] unlock_thr;

    logic [15:0] k1, k2, err_avg;
    logic        integ_clr, locked, fail;
    logic [1:0]  state;

    logic [15:0] k1_t, k2_t, err_avg_t;
    logic        integ_clr_t, locked_t, fail_t;
    logic [1:0]  state_t;

    int          checks;
    int          errors;
    int unsigned macc;
    int unsigned pre;
    int          mgood;
    int          mbad;
    int          samples;
    logic        done;
    logic        v;
    logic        exp_clr;
    logic [15:0] ev;
    logic [15:0] exp_k1;
    logic [15:0] exp_k2;
    vec_t        vecs [6];

    pi_loop_gain_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .zs_valid   (zs_valid),
        .e_k_zs     (e_k_zs),
        .lock_thr   (lock_thr),
        .unlock_thr (unlock_thr),
        .k1         (k1),
        .k2         (k2),
        .integ_clr  (integ_clr),
        .locked     (locked),
        .fail       (fail),
        .state      (state),
        .err_avg    (err_avg)
    );

    pi_loop_gain_scheduler #(
        .LOCK_CNT    (8),
        .ACQ_TIMEOUT (16)
    ) dut_t (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable_t),
        .zs_valid   (zs_valid),
        .e_k_zs     (e_k_zs),
        .lock_thr   (lock_thr),
        .unlock_thr (unlock_thr),
        .k1         (k1_t),
        .k2         (k2_t),
        .integ_clr  (integ_clr_t),
        .locked     (locked_t),
        .fail       (fail_t),
        .state      (state_t),
        .err_avg    (err_avg_t)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample at the falling edge and wait through the next rising edge
    task automatic applyStimulus(input logic valid, input logic [15:0] e);
        zs_valid = valid;
        e_k_zs   = e;
        @(negedge clk);
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference leaky averager with a saturating magnitude
    function automatic int unsigned modelStep(input int unsigned a, input logic [15:0] e);
        int mag;
        mag = int'($signed(e));
        if (mag < 0)
            mag = -mag;
        if (mag > 32767)
            mag = 32767;
        return a + int'(mag) - (a >> 4);
    endfunction

    // Main test sequence
    initial begin
        checks = 0;
        errors = 0;
        // Start from an accumulator of all ones and apply the vectors in order.
        // Each expected average below is hand-computed from the previous one.
        vecs[0] = '{1'b1, 16'h0000, 16'hF000, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'hF000, 1'b0};
        vecs[2] = '{1'b1, 16'h8000, 16'hE8FF, 1'b0};
        vecs[3] = '{1'b1, 16'h7FFF, 16'hE26F, 1'b0};
        vecs[4] = '{1'b1, 16'hFFF0, 16'hD44A, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'hD44A, 1'b0};

        rst_n      = 1'b0;
        enable     = 1'b0;
        enable_t   = 1'b0;
        zs_valid   = 1'b0;
        e_k_zs     = 16'h0000;
        lock_thr   = 16'h0000;
        unlock_thr = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset / idle");
        checkOutput("rst_state", state, 2'd0);
        checkOutput("rst_k1", k1, 16'h0000);
        checkOutput("rst_k2", k2, 16'h0000);
        checkOutput("rst_integ_clr", integ_clr, 1'b1);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_fail", fail, 1'b0);
        checkOutput("rst_err_avg", err_avg, 16'h0000);

        $display("[TB] acquisition entry");
        enable = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        checkOutput("acq_state", state, 2'd1);
        checkOutput("acq_k1", k1, 16'h0100);
        checkOutput("acq_k2", k2, 16'h0020);
        checkOutput("acq_integ_clr", integ_clr, 1'b1);
        checkOutput("acq_err_avg", err_avg, 16'hFFFF);

        $display("[TB] averager vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].e);
            checkOutput("vec_err_avg", err_avg, vecs[i].exp_avg);
            checkOutput("vec_integ_clr", integ_clr, vecs[i].exp_clr);
            checkOutput("vec_state", state, 2'd1);
            checkOutput("vec_k1", k1, 16'h0100);
        end

        $display("[TB] clean lock");
        macc     = 32'h000D44A0;
        mgood    = 0;
        done     = 1'b0;
        lock_thr = 16'h0100;
        for (int i = 0; i < 400 && !done; i++) begin
            ev    = i[0] ? 16'hFFF0 : 16'h0010;
            pre   = macc >> 4;
            mgood = (pre < 32'h100) ? mgood + 1 : 0;
            macc  = modelStep(macc, ev);
            applyStimulus(1'b1, ev);
            if (mgood == 64) begin
                done = 1'b1;
`ifdef PI_GAIN_RAMP_EN
                exp_k1 = 16'h0100;
                exp_k2 = 16'h0020;
`else
                exp_k1 = 16'h0020;
                exp_k2 = 16'h0004;
`endif
                checkOutput("lock_state", state, 2'd2);
                checkOutput("lock_locked", locked, 1'b1);
                checkOutput("lock_k1", k1, exp_k1);
                checkOutput("lock_k2", k2, exp_k2);
                checkOutput("lock_integ_clr", integ_clr, 1'b0);
                checkOutput("lock_err_avg", err_avg, 16'(macc >> 4));
            end else begin
                checkOutput("acq_wait_state", state, 2'd1);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL clean_lock_budget: lock not reached, required within 400 samples");
        end

        $display("[TB] tracking gains");
        for (int j = 1; j <= 32; j++) begin
            ev   = j[0] ? 16'hFFF0 : 16'h0010;
            macc = modelStep(macc, ev);
            applyStimulus(1'b1, ev);
`ifdef PI_GAIN_RAMP_EN
            exp_k1 = 16'h0100;
            exp_k2 = 16'h0020;
            exp_k1 = exp_k1 >> (j / 8);
            exp_k2 = exp_k2 >> (j / 8);
            if (exp_k1 < 16'h0020)
                exp_k1 = 16'h0020;
            if (exp_k2 < 16'h0004)
                exp_k2 = 16'h0004;
`else
            exp_k1 = 16'h0020;
            exp_k2 = 16'h0004;
`endif
            checkOutput("trk_k1", k1, exp_k1);
            checkOutput("trk_k2", k2, exp_k2);
            checkOutput("trk_locked", locked, 1'b1);
        end

        $display("[TB] unlock");
        unlock_thr = 16'h0800;
        mbad       = 0;
        done       = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            pre  = macc >> 4;
            mbad = (pre > 32'h800) ? mbad + 1 : 0;
            macc = modelStep(macc, 16'h4000);
            applyStimulus(1'b1, 16'h4000);
            if (mbad == 32) begin
                done = 1'b1;
                checkOutput("unlock_state", state, 2'd1);
                checkOutput("unlock_locked", locked, 1'b0);
                checkOutput("unlock_integ_clr", integ_clr, 1'b1);
                checkOutput("unlock_k1", k1, 16'h0100);
                checkOutput("unlock_k2", k2, 16'h0020);
                checkOutput("unlock_err_avg", err_avg, 16'hFFFF);
            end else begin
                checkOutput("trk_wait_state", state, 2'd2);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL unlock_budget: unlock not reached, required within 200 samples");
        end
        applyStimulus(1'b0, 16'h4000);
        checkOutput("unlock_clr_pulse_end", integ_clr, 1'b0);
        checkOutput("unlock_state_hold", state, 2'd1);

        enable = 1'b0;
        applyStimulus(1'b0, 16'h0000);
        checkOutput("disable_state", state, 2'd0);
        checkOutput("disable_k1", k1, 16'h0000);
        checkOutput("disable_integ_clr", integ_clr, 1'b1);

        $display("[TB] timeout / retry / fail");
        lock_thr   = 16'h0000;
        unlock_thr = 16'hFFFF;
        enable_t   = 1'b1;
        applyStimulus(1'b0, 16'h7FFF);
        checkOutput("to_entry_state", state_t, 2'd1);
        checkOutput("to_entry_clr", integ_clr_t, 1'b1);
        checkOutput("to_entry_k1", k1_t, 16'h0100);
        samples = 0;
        for (int cyc = 0; cyc < 100 && samples < 48; cyc++) begin
            v = ((cyc % 5) != 3);
            if (v)
                samples++;
            applyStimulus(v, 16'h7FFF);
            if (v && samples == 48) begin
                checkOutput("fail_state", state_t, 2'd3);
                checkOutput("fail_flag", fail_t, 1'b1);
                checkOutput("fail_k1", k1_t, 16'h0000);
                checkOutput("fail_k2", k2_t, 16'h0000);
                checkOutput("fail_integ_clr", integ_clr_t, 1'b1);
            end else begin
                exp_clr = v && ((samples % 16) == 0);
                checkOutput("retry_integ_clr", integ_clr_t, exp_clr);
                checkOutput("retry_state", state_t, 2'd1);
            end
        end
        applyStimulus(1'b1, 16'h7FFF);
        checkOutput("fail_hold_state", state_t, 2'd3);
        enable_t = 1'b0;
        applyStimulus(1'b0, 16'h7FFF);
        checkOutput("fail_exit_state", state_t, 2'd0);
        checkOutput("fail_exit_flag", fail_t, 1'b0);
        checkOutput("fail_exit_clr", integ_clr_t, 1'b1);

        $display("[TB] lock and timeout on the same sample");
        enable_t = 1'b1;
        applyStimulus(1'b0, 16'h7FFF);
        checkOutput("coin_entry_state", state_t, 2'd1);
        for (int k = 1; k <= 16; k++) begin
            lock_thr = (k == 1 || k == 8) ? 16'h0000 : 16'hFFFF;
            applyStimulus(1'b1, 16'h7FFF);
            checkOutput("coin_state", state_t, (k == 16) ? 2'd2 : 2'd1);
        end
        checkOutput("coin_locked", locked_t, 1'b1);
        checkOutput("coin_integ_clr", integ_clr_t, 1'b0);
        checkOutput("coin_fail", fail_t, 1'b0);

        $display("[TB] asynchronous reset in tracking");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_state", state_t, 2'd0);
        checkOutput("areset_locked", locked_t, 1'b0);
        checkOutput("areset_k1", k1_t, 16'h0000);
        checkOutput("areset_k2", k2_t, 16'h0000);
        checkOutput("areset_integ_clr", integ_clr_t, 1'b1);
        checkOutput("areset_err_avg", err_avg_t, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
